// File: rtl/pistorm_bus_pkg.sv
// Shared types and constants for the PiStorm bus engine: FSM states, response codes,
// transfer sizes, 6800-cycle E-count markers and byte-lane helpers.
package pistorm_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_S1, ST_S2, ST_S3, ST_S4, ST_SW, ST_S5, ST_S6, ST_S7
  } bus_state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BERR    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } rsp_err_e;

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_WORD = 1'b1
  } cmd_size_e;

  localparam int VPA_E_CNT = 2;
  localparam int VMA_E_CNT = 8;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  err;
  } rsp_t;

  // Byte reads come back zero-extended from the lane picked by A0.
  function automatic logic [15:0] lane_rd(input logic [15:0] d, input logic word, input logic a0);
    if (word) return d;
    return a0 ? {8'h00, d[7:0]} : {8'h00, d[15:8]};
  endfunction

  function automatic logic [15:0] lane_wr(input logic [15:0] d, input logic word);
    return word ? d : {d[7:0], d[7:0]};
  endfunction

endpackage

// File: rtl/pistorm_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty/count; DEPTH must be a power of two >= 2.
module pistorm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/pistorm_bus_engine.sv
// Queued MC68000 / 6800-synchronous bus-cycle engine running entirely in PI_CLK.
// Define M68K_BUS_TIMEOUT_EN to enable the DTACK watchdog (RSP_ERR = 10 on expiry).
module pistorm_bus_engine
  import pistorm_bus_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int DEPTH       = 4,
  parameter int E_DIV       = 10,
  parameter int E_HIGH      = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              PI_CLK,
  input  logic              SYS_RESET_n,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [ADDR_W-1:0] CMD_ADDR,
  input  logic              CMD_RW,
  input  logic              CMD_SIZE,
  input  logic [2:0]        CMD_FC,
  input  logic [15:0]       CMD_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [15:0]       RSP_DATA,
  output logic [1:0]        RSP_ERR,
  input  logic              M68K_CLK,
  output logic [ADDR_W-2:0] M68K_A,
  output logic [15:0]       M68K_D_OUT,
  output logic              M68K_D_OE,
  input  logic [15:0]       M68K_D_IN,
  output logic [2:0]        M68K_FC,
  output logic              M68K_AS_n,
  output logic              M68K_UDS_n,
  output logic              M68K_LDS_n,
  output logic              M68K_RW,
  input  logic              M68K_DTACK_n,
  input  logic              M68K_BERR_n,
  input  logic              M68K_VPA_n,
  output logic              M68K_E,
  output logic              M68K_VMA_n,
  output logic              BUSY
);

`ifdef M68K_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int CW   = ADDR_W + 21;
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam int ECW  = $clog2(E_DIV);
  localparam int WDW  = $clog2(TIMEOUT_CYC + 1);

  // M68K_CLK synchroniser and edge detect
  logic [2:0] r_msync;
  logic       w_rise, w_fall;
  assign w_rise = r_msync[1] & ~r_msync[2];
  assign w_fall = ~r_msync[1] & r_msync[2];

  logic [ECW-1:0] r_ecnt;
  logic           r_live;

  // command / response FIFOs
  logic [CW-1:0]   w_cmd_in, w_cmd;
  logic            w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic [CNTW-1:0] w_cmd_cnt;
  rsp_t            w_rsp, w_rsp_head;
  logic            w_rsp_push, w_rsp_pop, w_rsp_full, w_rsp_empty;
  logic [CNTW-1:0] w_rsp_cnt;

  assign w_cmd_in   = {CMD_ADDR, CMD_RW, CMD_SIZE, CMD_FC, CMD_DATA};
  assign w_cmd_push = CMD_VALID & CMD_READY;
  assign w_rsp_pop  = RSP_VALID & RSP_READY;

  pistorm_sync_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(PI_CLK), .rst_n(SYS_RESET_n),
    .i_push(w_cmd_push), .i_din(w_cmd_in), .i_pop(w_cmd_pop),
    .o_dout(w_cmd), .o_full(w_cmd_full), .o_empty(w_cmd_empty), .o_count(w_cmd_cnt)
  );

  pistorm_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk(PI_CLK), .rst_n(SYS_RESET_n),
    .i_push(w_rsp_push), .i_din(w_rsp), .i_pop(w_rsp_pop),
    .o_dout(w_rsp_head), .o_full(w_rsp_full), .o_empty(w_rsp_empty), .o_count(w_rsp_cnt)
  );

  logic [ADDR_W-1:0] w_cmd_addr;
  logic              w_cmd_rw, w_cmd_word;
  logic [2:0]        w_cmd_fc;
  logic [15:0]       w_cmd_data;
  assign {w_cmd_addr, w_cmd_rw, w_cmd_word, w_cmd_fc, w_cmd_data} = w_cmd;

  // bus-side registers and their next values
  bus_state_e        r_state, w_nxt_state;
  logic              r_as_n, r_uds_n, r_lds_n, r_vma_n, r_rw, r_d_oe;
  logic              w_nxt_as_n, w_nxt_uds_n, w_nxt_lds_n, w_nxt_vma_n, w_nxt_rw, w_nxt_d_oe;
  logic [2:0]        r_fc, w_nxt_fc;
  logic [ADDR_W-2:0] r_a, w_nxt_a;
  logic [15:0]       r_dout, w_nxt_dout;
  logic              r_cur_rw, r_cur_word, r_cur_a0;
  logic              w_nxt_cur_rw, w_nxt_cur_word, w_nxt_cur_a0;
  logic [WDW-1:0]    r_wd, w_nxt_wd;
  logic              w_finish, w_uds_sel, w_lds_sel, w_inflight;

  assign w_uds_sel  = r_cur_word | ~r_cur_a0;
  assign w_lds_sel  = r_cur_word | r_cur_a0;
  assign w_inflight = (r_state != ST_IDLE) && (r_state != ST_S7);

  // A response slot is reserved for every accepted command, so S6->S7 never blocks.
  logic [CNTW:0] w_used;
  assign w_used = (CNTW+1)'(w_cmd_cnt) + (CNTW+1)'(w_rsp_cnt) + (CNTW+1)'(w_inflight);

  assign CMD_READY = r_live & ~w_cmd_full & ~w_rsp_full & (w_used < (CNTW+1)'(DEPTH));
  assign RSP_VALID = ~w_rsp_empty;
  assign RSP_DATA  = w_rsp_head.data;
  assign RSP_ERR   = w_rsp_head.err;
  assign BUSY      = (w_cmd_cnt != '0) | (w_rsp_cnt != '0) | (r_state != ST_IDLE);

  assign M68K_A     = r_a;
  assign M68K_D_OUT = r_dout;
  assign M68K_D_OE  = r_d_oe;
  assign M68K_FC    = r_fc;
  assign M68K_AS_n  = r_as_n;
  assign M68K_UDS_n = r_uds_n;
  assign M68K_LDS_n = r_lds_n;
  assign M68K_RW    = r_rw;
  assign M68K_VMA_n = r_vma_n;
  assign M68K_E     = (r_ecnt >= ECW'(E_DIV - E_HIGH));

  always_ff @(posedge PI_CLK or negedge SYS_RESET_n) begin
    if (!SYS_RESET_n) begin
      r_msync <= '0;
      r_ecnt  <= '0;
      r_live  <= 1'b0;
    end else begin
      r_msync <= {r_msync[1:0], M68K_CLK};
      r_live  <= 1'b1;
      if (w_fall) r_ecnt <= (r_ecnt == ECW'(E_DIV - 1)) ? '0 : r_ecnt + 1'b1;
    end
  end

  always_ff @(posedge PI_CLK or negedge SYS_RESET_n) begin
    if (!SYS_RESET_n) begin
      r_state    <= ST_IDLE;
      r_as_n     <= 1'b1;
      r_uds_n    <= 1'b1;
      r_lds_n    <= 1'b1;
      r_vma_n    <= 1'b1;
      r_rw       <= 1'b1;
      r_d_oe     <= 1'b0;
      r_fc       <= '0;
      r_a        <= '0;
      r_dout     <= '0;
      r_cur_rw   <= 1'b1;
      r_cur_word <= 1'b0;
      r_cur_a0   <= 1'b0;
      r_wd       <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_as_n     <= w_nxt_as_n;
      r_uds_n    <= w_nxt_uds_n;
      r_lds_n    <= w_nxt_lds_n;
      r_vma_n    <= w_nxt_vma_n;
      r_rw       <= w_nxt_rw;
      r_d_oe     <= w_nxt_d_oe;
      r_fc       <= w_nxt_fc;
      r_a        <= w_nxt_a;
      r_dout     <= w_nxt_dout;
      r_cur_rw   <= w_nxt_cur_rw;
      r_cur_word <= w_nxt_cur_word;
      r_cur_a0   <= w_nxt_cur_a0;
      r_wd       <= w_nxt_wd;
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_as_n     = r_as_n;
    w_nxt_uds_n    = r_uds_n;
    w_nxt_lds_n    = r_lds_n;
    w_nxt_vma_n    = r_vma_n;
    w_nxt_rw       = r_rw;
    w_nxt_d_oe     = r_d_oe;
    w_nxt_fc       = r_fc;
    w_nxt_a        = r_a;
    w_nxt_dout     = r_dout;
    w_nxt_cur_rw   = r_cur_rw;
    w_nxt_cur_word = r_cur_word;
    w_nxt_cur_a0   = r_cur_a0;
    w_nxt_wd       = (r_state == ST_SW) ? r_wd : '0;
    w_cmd_pop      = 1'b0;
    w_rsp_push     = 1'b0;
    w_finish       = 1'b0;
    w_rsp.data     = 16'h0000;
    w_rsp.err      = ERR_OK;

    case (r_state)
      ST_IDLE: if (w_fall && !w_cmd_empty) begin
        w_cmd_pop      = 1'b1;
        w_nxt_state    = ST_S1;
        w_nxt_a        = w_cmd_addr[ADDR_W-1:1];
        w_nxt_fc       = w_cmd_fc;
        w_nxt_rw       = w_cmd_rw;
        w_nxt_dout     = lane_wr(w_cmd_data, w_cmd_word);
        w_nxt_cur_rw   = w_cmd_rw;
        w_nxt_cur_word = w_cmd_word;
        w_nxt_cur_a0   = w_cmd_addr[0];
      end
      ST_S1: if (w_rise) begin
        w_nxt_state = ST_S2;
        w_nxt_as_n  = 1'b0;
        if (r_cur_rw) begin
          w_nxt_uds_n = ~w_uds_sel;
          w_nxt_lds_n = ~w_lds_sel;
        end
      end
      ST_S2: if (w_fall) begin
        w_nxt_state = ST_S3;
        if (!r_cur_rw) w_nxt_d_oe = 1'b1;
      end
      ST_S3: if (w_rise) begin
        w_nxt_state = ST_S4;
        if (!r_cur_rw) begin
          w_nxt_uds_n = ~w_uds_sel;
          w_nxt_lds_n = ~w_lds_sel;
        end
      end
      // BERR outranks DTACK; the 6800 path terminates on VMA plus the E count.
      ST_S4, ST_SW: if (w_fall) begin
        if (!M68K_BERR_n) begin
          w_finish  = 1'b1;
          w_rsp.err = ERR_BERR;
        end else if (!M68K_DTACK_n || (!r_vma_n && r_ecnt == ECW'(VMA_E_CNT))) begin
          w_nxt_state = ST_S5;
        end else if (TO_EN && r_state == ST_SW && r_wd == WDW'(TIMEOUT_CYC - 1)) begin
          w_finish  = 1'b1;
          w_rsp.err = ERR_TIMEOUT;
        end else begin
          w_nxt_state = ST_SW;
          if (r_state == ST_SW) begin
            if (!M68K_VPA_n && r_ecnt == ECW'(VPA_E_CNT)) w_nxt_vma_n = 1'b0;
            if (TO_EN) w_nxt_wd = r_wd + 1'b1;
          end
        end
      end
      ST_S5: if (w_rise) w_nxt_state = ST_S6;
      ST_S6: if (w_fall) begin
        w_finish = 1'b1;
        if (r_cur_rw) w_rsp.data = lane_rd(M68K_D_IN, r_cur_word, r_cur_a0);
      end
      ST_S7: if (w_rise) begin
        w_nxt_state = ST_IDLE;
        w_nxt_rw    = 1'b1;
        w_nxt_d_oe  = 1'b0;
      end
      default: w_nxt_state = ST_IDLE;
    endcase

    if (w_finish) begin
      w_nxt_state = ST_S7;
      w_nxt_as_n  = 1'b1;
      w_nxt_uds_n = 1'b1;
      w_nxt_lds_n = 1'b1;
      w_nxt_vma_n = 1'b1;
      w_nxt_wd    = '0;
      w_rsp_push  = 1'b1;
    end
  end

endmodule

// File: tb/tb_pistorm_bus_engine.sv
// Scoreboard bench for pistorm_bus_engine: directed bus cycles, responses checked by a monitor.
module tb_pistorm_bus_engine;

  logic        PI_CLK = 1'b0, SYS_RESET_n = 1'b0, M68K_CLK = 1'b0;
  logic        CMD_VALID = 1'b0, CMD_RW = 1'b1, CMD_SIZE = 1'b0, RSP_READY = 1'b1;
  logic [23:0] CMD_ADDR = '0;
  logic [2:0]  CMD_FC = '0;
  logic [15:0] CMD_DATA = '0;
  logic        CMD_READY, RSP_VALID, M68K_D_OE, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW;
  logic        M68K_E, M68K_VMA_n, BUSY, M68K_DTACK_n, M68K_BERR_n, M68K_VPA_n;
  logic [15:0] RSP_DATA, M68K_D_OUT, M68K_D_IN;
  logic [1:0]  RSP_ERR;
  logic [22:0] M68K_A;
  logic [2:0]  M68K_FC;

  int total = 0, bad = 0;
  int mode = 1;              // 0: silent slave, 1: DTACK slave, 2: VPA slave
  logic berr_drv = 1'b0;
  logic [15:0] rd_word = 16'h1234;
  logic [17:0] exp_q[$];
  longint t_efall = 0;
  logic e_prev = 1'b0;

  always #5 PI_CLK = ~PI_CLK;
  always #70 M68K_CLK = ~M68K_CLK;

  assign M68K_DTACK_n = !(mode == 1 && !M68K_AS_n && (!M68K_UDS_n || !M68K_LDS_n));
  assign M68K_VPA_n   = !(mode == 2 && !M68K_AS_n);
  assign M68K_BERR_n  = !berr_drv;
  assign M68K_D_IN    = rd_word ^ {M68K_A[7:0], M68K_A[7:0]};

  pistorm_bus_engine dut (
    .PI_CLK(PI_CLK), .SYS_RESET_n(SYS_RESET_n),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_ADDR(CMD_ADDR), .CMD_RW(CMD_RW),
    .CMD_SIZE(CMD_SIZE), .CMD_FC(CMD_FC), .CMD_DATA(CMD_DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .M68K_CLK(M68K_CLK), .M68K_A(M68K_A), .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE),
    .M68K_D_IN(M68K_D_IN), .M68K_FC(M68K_FC), .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n),
    .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW), .M68K_DTACK_n(M68K_DTACK_n),
    .M68K_BERR_n(M68K_BERR_n), .M68K_VPA_n(M68K_VPA_n), .M68K_E(M68K_E),
    .M68K_VMA_n(M68K_VMA_n), .BUSY(BUSY)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // response monitor: a transfer happens on the posedge following this sample
  always @(negedge PI_CLK) begin
    if (SYS_RESET_n && RSP_VALID && RSP_READY) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got data=%0h err=%0h want none", RSP_DATA, RSP_ERR);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({RSP_DATA, RSP_ERR} !== e) begin
          bad++;
          $display("FAIL rsp: got data=%0h err=%0h want data=%0h err=%0h",
                   RSP_DATA, RSP_ERR, e[17:2], e[1:0]);
        end
      end
    end
  end

  always @(negedge PI_CLK) begin
    if (e_prev && !M68K_E) t_efall = $time;
    e_prev = M68K_E;
  end

  function automatic logic sigv(input int s);
    case (s)
      0: return M68K_AS_n;
      1: return M68K_LDS_n;
      2: return M68K_UDS_n;
      3: return M68K_VMA_n;
      default: return BUSY;
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int s, input logic v, input int maxc, output longint t);
    bit ok = 0;
    t = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge PI_CLK);
      if (sigv(s) === v) begin ok = 1; t = $time; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: bound expired, got %0b want %0b", nm, sigv(s), v);
    end
  endtask

  task automatic send(input logic [23:0] a, input logic rw, input logic sz, input logic [2:0] fc,
                      input logic [15:0] d, input bit exp_en, input logic [15:0] ed, input logic [1:0] ee);
    bit ok = 0;
    @(negedge PI_CLK);
    CMD_ADDR = a; CMD_RW = rw; CMD_SIZE = sz; CMD_FC = fc; CMD_DATA = d; CMD_VALID = 1'b1;
    if (exp_en) exp_q.push_back({ed, ee});
    for (int i = 0; i < 2000; i++) begin
      if (CMD_READY) begin ok = 1; break; end
      @(negedge PI_CLK);
    end
    if (ok) begin
      @(posedge PI_CLK); #1;
    end else begin
      total++; bad++;
      $display("FAIL cmd_accept: CMD_READY got 0 want 1");
    end
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge PI_CLK);
      if (!BUSY && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL idle: BUSY got %0b, pending responses %0d want 0", BUSY, exp_q.size());
    end
  endtask

  initial begin
    longint t0, t1, t2;
    #23;
    chk("rst_as", M68K_AS_n, 1);     chk("rst_uds", M68K_UDS_n, 1);
    chk("rst_lds", M68K_LDS_n, 1);   chk("rst_vma", M68K_VMA_n, 1);
    chk("rst_rw", M68K_RW, 1);       chk("rst_fc", M68K_FC, 0);
    chk("rst_a", M68K_A, 0);         chk("rst_doe", M68K_D_OE, 0);
    chk("rst_e", M68K_E, 0);         chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_rsp_valid", RSP_VALID, 0); chk("rst_busy", BUSY, 0);
    repeat (10) @(negedge PI_CLK);
    SYS_RESET_n = 1'b1;

    // word read, DTACK slave
    mode = 1;
    send(24'hBFE001, 1'b1, 1'b1, 3'd5, 16'h0, 1, 16'h1234, 2'b00);
    wait_sig("t1_as_fall", 0, 1'b0, 500, t0);
    chk("t1_uds", M68K_UDS_n, 0);  chk("t1_lds", M68K_LDS_n, 0);
    chk("t1_addr", M68K_A, 23'h5FF000); chk("t1_fc", M68K_FC, 5);
    chk("t1_rw", M68K_RW, 1);
    wait_sig("t1_as_rise", 0, 1'b1, 500, t1);
    chk("t1_as_low_time", 32'(t1 - t0), 350);
    wait_idle(500);

    // byte write to odd address: lower lane only, data mirrored
    send(24'hDFF181, 1'b0, 1'b0, 3'd1, 16'hA55A, 1, 16'h0000, 2'b00);
    wait_sig("t2_as_fall", 0, 1'b0, 500, t0);
    chk("t2_doe_at_s2", M68K_D_OE, 0); chk("t2_lds_at_s2", M68K_LDS_n, 1);
    chk("t2_addr", M68K_A, 23'h6FF8C0); chk("t2_rw", M68K_RW, 0);
    wait_sig("t2_lds_fall", 1, 1'b0, 500, t1);
    chk("t2_lds_delay", 32'(t1 - t0), 140);
    chk("t2_dout", M68K_D_OUT, 16'h5A5A); chk("t2_doe", M68K_D_OE, 1);
    chk("t2_uds", M68K_UDS_n, 1);
    wait_idle(500);
    chk("t2_doe_after", M68K_D_OE, 0);

    // four queued reads with the response side stalled
    @(negedge PI_CLK); RSP_READY = 1'b0;
    send(24'h000100, 1'b1, 1'b1, 3'd5, 16'h0, 1, 16'h92B4, 2'b00);
    send(24'h000102, 1'b1, 1'b1, 3'd5, 16'h0, 1, 16'h93B5, 2'b00);
    send(24'h000105, 1'b1, 1'b0, 3'd5, 16'h0, 1, 16'h00B6, 2'b00);
    send(24'h000106, 1'b1, 1'b0, 3'd5, 16'h0, 1, 16'h0091, 2'b00);
    @(negedge PI_CLK);
    chk("t3_ready_after4", CMD_READY, 0);
    repeat (400) @(negedge PI_CLK);
    chk("t3_rsp_held", RSP_VALID, 1); chk("t3_ready_held", CMD_READY, 0);
    RSP_READY = 1'b1;
    wait_idle(500);
    chk("t3_ready_back", CMD_READY, 1);

    // 6800 cycle via VPA, no DTACK
    mode = 2;
    send(24'hBFD000, 1'b1, 1'b1, 3'd5, 16'h0, 1, 16'h1234, 2'b00);
    wait_sig("t4_as_fall", 0, 1'b0, 500, t0);
    wait_sig("t4_vma_fall", 3, 1'b0, 2000, t1);
    chk("t4_vma_vs_efall", 32'(t1 - t_efall), 420);
    wait_sig("t4_as_rise", 0, 1'b1, 2000, t2);
    chk("t4_end_vs_vma", 32'(t2 - t1), 980);
    chk("t4_vma_neg", M68K_VMA_n, 1);
    wait_idle(500);

    // bus error while waiting
    mode = 0;
    send(24'h000200, 1'b1, 1'b1, 3'd5, 16'h0, 1, 16'h0000, 2'b01);
    wait_sig("t5_as_fall", 0, 1'b0, 500, t0);
    repeat (60) @(negedge PI_CLK);
    berr_drv = 1'b1; t1 = $time;
    wait_sig("t5_as_rise", 0, 1'b1, 100, t2);
    chk("t5_berr_latency_ok", (t2 - t1) <= 160, 1);
    berr_drv = 1'b0;
    wait_idle(500);

`ifdef M68K_BUS_TIMEOUT_EN
    send(24'h000300, 1'b1, 1'b1, 3'd5, 16'h0, 1, 16'h0000, 2'b10);
    wait_idle(6000);
`endif

    // reset in the middle of a cycle with another command queued
    send(24'h000400, 1'b1, 1'b1, 3'd5, 16'h0, 0, 16'h0, 2'b00);
    send(24'h000500, 1'b1, 1'b1, 3'd5, 16'h0, 0, 16'h0, 2'b00);
    wait_sig("t6_as_fall", 0, 1'b0, 500, t0);
    repeat (17) @(negedge PI_CLK);
    SYS_RESET_n = 1'b0;
    #1;
    chk("t6_as", M68K_AS_n, 1); chk("t6_uds", M68K_UDS_n, 1); chk("t6_lds", M68K_LDS_n, 1);
    chk("t6_ready", CMD_READY, 0); chk("t6_busy", BUSY, 0);
    repeat (3) @(negedge PI_CLK);
    SYS_RESET_n = 1'b1;
    repeat (200) @(negedge PI_CLK);
    chk("t6_no_rsp", RSP_VALID, 0); chk("t6_idle", BUSY, 0); chk("t6_as_idle", M68K_AS_n, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
